// File: rtl/serial_add_sequencer_pkg.sv
// rtl/serial_add_sequencer_pkg.sv - shared state encoding and handshake helper for serial-datapath sequencers
package serial_add_sequencer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } seq_state_t;

    function automatic logic hs_fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - 1-bit full adder built from two half adders
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s0, c0, c1;

    half_adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .carry(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .sum(sum), .carry(c1));

    assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - 1-bit half adder
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - bit-serial adder: one shared full_adder, LSB-first, valid/ready job in and result out
module serial_add_sequencer
    import serial_add_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    seq_state_t       state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg, sum_shift, sum_out;
    logic [CNT_W-1:0] cnt;
    logic             carry_reg, cout_out;
    logic             fa_sum, fa_cout;
    logic             accept, release_fire, last_bit;

    full_adder u_fa (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at index 0.
    if (WIDTH == 1) begin : g_shift_w1
        assign sum_shift = fa_sum;
    end else begin : g_shift_wn
        assign sum_shift = {fa_sum, sum_reg[WIDTH-1:1]};
    end

    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == DONE);
    assign busy         = (state != IDLE);
    assign sum          = sum_out;
    assign carry_out    = cout_out;
    assign accept       = hs_fire(in_valid, in_ready);
    assign release_fire = hs_fire(out_valid, out_ready);
    assign last_bit     = (cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)       state_nxt = RUN;
            RUN:     if (last_bit)     state_nxt = DONE;
            DONE:    if (release_fire) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Visible result registers only update on the final bit, so a job
    // aborted by reset never exposes a partial sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            sum_out   <= '0;
            carry_reg <= 1'b0;
            cout_out  <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= carry_in;
                        sum_reg   <= '0;
                        cnt       <= '0;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_shift;
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    carry_reg <= fa_cout;
                    if (last_bit) begin
                        cnt      <= '0;
                        sum_out  <= sum_shift;
                        cout_out <= fa_cout;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - randomized self-checking bench for serial_add_sequencer at WIDTH 8, 1 and 13
module tb_serial_add_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, cin;
    logic [12:0] a_in, b_in;
    logic [1:0]  sel;

    logic [2:0]  iv_v, orr_v, ir_v, ov_v, bz_v, co_v;
    logic [7:0]  sum8;
    logic [0:0]  sum1;
    logic [12:0] sum13;
    logic [12:0] obs_sum;
    logic        obs_in_ready, obs_out_valid, obs_busy, obs_cout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign iv_v[0]  = in_valid  && (sel == 2'd0);
    assign iv_v[1]  = in_valid  && (sel == 2'd1);
    assign iv_v[2]  = in_valid  && (sel == 2'd2);
    assign orr_v[0] = out_ready && (sel == 2'd0);
    assign orr_v[1] = out_ready && (sel == 2'd1);
    assign orr_v[2] = out_ready && (sel == 2'd2);

    serial_add_sequencer #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_v[0]), .in_ready(ir_v[0]),
        .a(a_in[7:0]), .b(b_in[7:0]), .carry_in(cin), .out_valid(ov_v[0]),
        .out_ready(orr_v[0]), .sum(sum8), .carry_out(co_v[0]), .busy(bz_v[0])
    );

    serial_add_sequencer #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_v[1]), .in_ready(ir_v[1]),
        .a(a_in[0:0]), .b(b_in[0:0]), .carry_in(cin), .out_valid(ov_v[1]),
        .out_ready(orr_v[1]), .sum(sum1), .carry_out(co_v[1]), .busy(bz_v[1])
    );

    serial_add_sequencer #(.WIDTH(13)) u_w13 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_v[2]), .in_ready(ir_v[2]),
        .a(a_in), .b(b_in), .carry_in(cin), .out_valid(ov_v[2]),
        .out_ready(orr_v[2]), .sum(sum13), .carry_out(co_v[2]), .busy(bz_v[2])
    );

    always_comb begin
        case (sel)
            2'd1:    obs_sum = {12'b0, sum1};
            2'd2:    obs_sum = sum13;
            default: obs_sum = {5'b0, sum8};
        endcase
        obs_in_ready  = ir_v[sel];
        obs_out_valid = ov_v[sel];
        obs_busy      = bz_v[sel];
        obs_cout      = co_v[sel];
    end

    function automatic int width_of(input logic [1:0] s);
        case (s)
            2'd1:    return 1;
            2'd2:    return 13;
            default: return 8;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (width %0d, t=%0t)", tag, got, exp, width_of(sel), $time);
        end
    endtask

    task automatic apply_reset;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    // noise: 0 = in_valid low while busy, 1 = random in_valid/operands, 2 = in_valid held with a=8'h12
    task automatic run_job(input logic [12:0] ja, input logic [12:0] jb, input logic jcin,
                           input int stall, input int noise);
        int          w;
        int          n;
        logic [13:0] mask;
        logic [13:0] total;
        logic [31:0] exp_sum;
        logic [31:0] exp_cout;
        w        = width_of(sel);
        mask     = (14'd1 << w) - 14'd1;
        total    = ({1'b0, ja} & mask) + ({1'b0, jb} & mask) + {13'b0, jcin};
        exp_sum  = 32'(total & mask);
        exp_cout = 32'((total >> w) & 14'd1);

        n = 0;
        while (!obs_in_ready && n < 50) begin
            tick;
            n++;
        end
        check("in_ready_idle", obs_in_ready, 1);

        a_in = ja; b_in = jb; cin = jcin; in_valid = 1'b1; out_ready = 1'b0;
        tick;
        n = 0;
        while (!obs_out_valid && n < 100) begin
            if (n == 0) begin
                check("busy_after_accept", obs_busy, 1);
                check("in_ready_run", obs_in_ready, 0);
            end
            case (noise)
                1: begin
                    in_valid = 1'($urandom);
                    a_in = 13'($urandom); b_in = 13'($urandom); cin = 1'($urandom);
                end
                2: begin
                    in_valid = 1'b1; a_in = 13'h12; b_in = 13'h0; cin = 1'b0;
                end
                default: in_valid = 1'b0;
            endcase
            tick;
            n++;
        end
        check("latency", n, w);
        check("sum", 32'(obs_sum), exp_sum);
        check("carry_out", 32'(obs_cout), exp_cout);

        repeat (stall) begin
            if (noise != 0) in_valid = 1'($urandom);
            tick;
            check("hold_valid", obs_out_valid, 1);
            check("hold_in_ready", obs_in_ready, 0);
            check("hold_sum", 32'(obs_sum), exp_sum);
        end

        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("release_valid", obs_out_valid, 0);
        check("release_no_accept", obs_busy, 0);
        check("kept_sum", 32'(obs_sum), exp_sum);
        check("kept_cout", 32'(obs_cout), exp_cout);
    endtask

    initial begin
        int          got;
        int          cyc;
        int          stamp [2];
        logic [12:0] rsum  [2];
        logic        rcout [2];

        sel = 2'd0; a_in = '0; b_in = '0; cin = 1'b0;
        apply_reset;

        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            check("rst_in_ready", obs_in_ready, 1);
            check("rst_out_valid", obs_out_valid, 0);
            check("rst_busy", obs_busy, 0);
            check("rst_sum", 32'(obs_sum), 0);
            check("rst_cout", 32'(obs_cout), 0);
        end

        sel = 2'd0;
        #1;
        run_job(13'hFF, 13'h01, 1'b0, 0, 0);
        run_job(13'h5A, 13'h3C, 1'b1, 5, 0);
        run_job(13'h33, 13'h44, 1'b0, 0, 2);
        run_job(13'h10, 13'h20, 1'b0, 0, 0);

        while (!obs_in_ready) tick;
        a_in = 13'hFF; b_in = 13'hFF; cin = 1'b1; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (3) tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("midrun_rst_valid", obs_out_valid, 0);
        check("midrun_rst_sum", 32'(obs_sum), 0);
        check("midrun_rst_cout", 32'(obs_cout), 0);
        check("midrun_rst_in_ready", obs_in_ready, 1);
        check("midrun_rst_busy", obs_busy, 0);
        repeat (12) begin
            tick;
            check("midrun_no_stale", obs_out_valid, 0);
        end

        apply_reset;
        a_in = 13'h80; b_in = 13'h80; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        a_in = 13'h01; b_in = 13'h01; cin = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 2 && cyc < 100) begin
            tick;
            cyc++;
            if (obs_out_valid) begin
                stamp[got] = cyc;
                rsum[got]  = obs_sum;
                rcout[got] = obs_cout;
                got++;
            end
        end
        check("b2b_count", got, 2);
        if (got == 2) begin
            check("b2b_first_latency", stamp[0], 8);
            check("b2b_spacing", stamp[1] - stamp[0], 10);
            check("b2b_sum0", 32'(rsum[0]), 32'h00);
            check("b2b_cout0", 32'(rcout[0]), 1);
            check("b2b_sum1", 32'(rsum[1]), 32'h03);
            check("b2b_cout1", 32'(rcout[1]), 0);
        end
        apply_reset;

        for (int i = 0; i < 1000; i++) begin
            sel = (i % 2 == 0) ? 2'd1 : 2'd2;
            #1;
            run_job(13'($urandom), 13'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
